// File: rtl/decomp_block_ctrl.sv
// decomp_block_ctrl: sequences the decompressor datapath over packed blocks
// of one 2-bit-code header word followed by byte-packed payload words.

module decompressor (
  input  logic [31:0] i_decomp_in,
  input  logic [1:0]  i_bitmap,
  output logic [31:0] o_decomp_out
);

  // 01/10 payloads are sign-extended narrow values, 11 is a raw word
  always_comb begin
    o_decomp_out = 32'h0;
    unique case (1'b1)
      (i_bitmap == 2'b01):
        o_decomp_out = {{24{i_decomp_in[7]}}, i_decomp_in[7:0]};
      (i_bitmap == 2'b10):
        o_decomp_out = {{16{i_decomp_in[15]}}, i_decomp_in[15:0]};
      (i_bitmap == 2'b11):
        o_decomp_out = i_decomp_in;
      default:
        o_decomp_out = 32'h0;
    endcase
  end

endmodule

module decomp_block_ctrl #(
  parameter int CODES_PER_HDR = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        block_done
);

  typedef enum logic {
    S_HDR  = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_hdr;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [4:0]  r_wleft;
  logic [63:0] r_buf;
  logic [31:0] r_out_data;
  logic        r_out_valid;
  logic        r_block_done;

  logic [6:0]  w_hdr_bytes;
  logic [6:0]  w_hdr_round;
  logic [4:0]  w_hdr_words;
  logic [1:0]  w_code;
  logic [3:0]  w_size;
  logic [3:0]  w_used;
  logic [3:0]  w_pos;
  logic [3:0]  w_cnt_nx;
  logic [63:0] w_shift;
  logic [63:0] w_app;
  logic [63:0] w_buf_nx;
  logic [31:0] w_dec;
  logic        w_can_fill;
  logic        w_fill;
  logic        w_hdr_acc;
  logic        w_emit;
  logic        w_last;

  function automatic logic [2:0] f_size(input logic [1:0] c);
    logic [2:0] s;
    s = 3'd0;
    unique case (1'b1)
      (c == 2'b01): s = 3'd1;
      (c == 2'b10): s = 3'd2;
      (c == 2'b11): s = 3'd4;
      default:      s = 3'd0;
    endcase
    return s;
  endfunction

  // payload length of an incoming header, in whole words
  always_comb begin
    w_hdr_bytes = 7'd0;
    for (int i = 0; i < CODES_PER_HDR; i++) begin
      w_hdr_bytes = w_hdr_bytes + {4'd0, f_size(in_data[2*i +: 2])};
    end
    w_hdr_round = w_hdr_bytes + 7'd3;
    w_hdr_words = w_hdr_round[6:2];
  end

  // handshake qualifiers and the shift-then-append byte buffer update
  always_comb begin
    w_code     = r_hdr[{r_idx, 1'b0} +: 2];
    w_size     = {1'b0, f_size(w_code)};
    w_can_fill = (r_state == S_EMIT) && (r_wleft != 5'd0)
                 && (r_cnt <= 4'd4);
    in_ready   = rst_n && ((r_state == S_HDR) || w_can_fill);
    w_fill     = in_valid && w_can_fill;
    w_hdr_acc  = in_valid && rst_n && (r_state == S_HDR);
    w_emit     = (r_state == S_EMIT) && (r_cnt >= w_size)
                 && (!r_out_valid || out_ready);
    w_last     = w_emit
                 && (r_idx == 4'(CODES_PER_HDR - 1));
    w_used     = w_emit ? w_size : 4'd0;
    w_pos      = r_cnt - w_used;
    w_shift    = r_buf >> {w_used, 3'b000};
    w_app      = {32'h0, in_data} << {w_pos, 3'b000};
    w_buf_nx   = w_fill ? (w_shift | w_app) : w_shift;
    w_cnt_nx   = w_pos + (w_fill ? 4'd4 : 4'd0);
  end

  decompressor u_decomp (
    .i_decomp_in  (r_buf[31:0]),
    .i_bitmap     (w_code),
    .o_decomp_out (w_dec)
  );

  // next-state: header starts a block, 16th emission ends it
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_HDR:  if (w_hdr_acc) w_state_nx = S_EMIT;
      S_EMIT: if (w_last)    w_state_nx = S_HDR;
      default: w_state_nx = S_HDR;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HDR;
    else        r_state <= w_state_nx;
  end

  // block bookkeeping: header, code index, byte buffer, words to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr   <= 32'h0;
      r_idx   <= 4'd0;
      r_cnt   <= 4'd0;
      r_wleft <= 5'd0;
      r_buf   <= 64'h0;
    end else if (w_hdr_acc) begin
      r_hdr   <= in_data;
      r_idx   <= 4'd0;
      r_cnt   <= 4'd0;
      r_wleft <= w_hdr_words;
      r_buf   <= 64'h0;
    end else if (r_state == S_EMIT) begin
      if (w_last) begin
        r_cnt <= 4'd0;
        r_buf <= 64'h0;
      end else begin
        r_cnt <= w_cnt_nx;
        r_buf <= w_buf_nx;
      end
      if (w_emit) r_idx   <= r_idx + 4'd1;
      if (w_fill) r_wleft <= r_wleft - 5'd1;
    end
  end

  // output register: load on emission, drop valid once taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= 32'h0;
      r_out_valid  <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= w_last;
      if (w_emit) begin
        r_out_data  <= w_dec;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign block_done = r_block_done;

endmodule
